uart_tx: RTL and testbench

- UART transmitter that serialises one byte per request onto a single TX line as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Sits beside the existing UART receiver and shares its 50 MHz clock, its `baudrate` select and its divider scheme, so a loopback of `uart_txd` into the receiver returns the sent byte.
- Accepts a byte on a start pulse, reports busy while shifting, and pulses done when the stop bit completes.

---
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter sharing the receiver's baud divider scheme.
// Optional even parity bit when UART_TX_PARITY_EN is defined; SIM shrinks the divider.
module uart_tx #(
`ifdef SIM
  parameter int unsigned                 T_DIV_BIT = 4,
  parameter logic [T_DIV_BIT-1:0]        T_DIV_0   = 4'd15,
  parameter logic [T_DIV_BIT-1:0]        T_DIV_1   = 4'd7
`else
  parameter int unsigned                 T_DIV_BIT = 13,
  parameter logic [T_DIV_BIT-1:0]        T_DIV_0   = 13'd5207,
  parameter logic [T_DIV_BIT-1:0]        T_DIV_1   = 13'd2603
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baudrate,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state;
  logic [7:0]           shift_reg;
  logic [2:0]           bit_cnt;
  logic [T_DIV_BIT-1:0] div_cnt;
  logic [T_DIV_BIT-1:0] div_latched;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  // Last clock of the current bit period; the divider wraps on the following edge.
  assign bit_end = (div_cnt == div_latched);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift_reg   <= 8'h00;
      bit_cnt     <= 3'd0;
      div_cnt     <= '0;
      div_latched <= T_DIV_0;
      uart_txd    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) begin
        div_cnt <= bit_end ? '0 : T_DIV_BIT'(div_cnt + 1'b1);
      end
      case (state)
        IDLE: begin
          if (tx_start) begin
            shift_reg   <= tx_data;
            div_latched <= baudrate ? T_DIV_1 : T_DIV_0;
            div_cnt     <= '0;
            bit_cnt     <= 3'd0;
            uart_txd    <= 1'b0;
            tx_busy     <= 1'b1;
            state       <= START;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= ^tx_data;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            uart_txd  <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= 3'd0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
              uart_txd <= parity_bit;
              state    <= PARITY;
`else
              uart_txd <= 1'b1;
              state    <= STOP;
`endif
            end else begin
              uart_txd  <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            uart_txd <= 1'b1;
            state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            uart_txd <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          uart_txd <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a bit-list frame model.
// Honours UART_TX_PARITY_EN for the expected frame length.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baudrate;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       uart_txd;
  logic       tx_busy;
  logic       tx_done;

  int vectors = 0;
  int errors  = 0;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  uart_tx #(
    .T_DIV_BIT(4),
    .T_DIV_0  (4'd15),
    .T_DIV_1  (4'd7)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .baudrate(baudrate),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .uart_txd(uart_txd),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  function automatic int period(input logic b);
    return b ? 8 : 16;
  endfunction

  // Expected line level j clocks after acceptance: start, data LSB first, [parity], stop.
  function automatic logic exp_txd(input logic [7:0] d, input int j, input int p);
    int idx;
    idx = j / p;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && NBITS == 11) return ^d;
    return 1'b1;
  endfunction

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic start_frame(input logic [7:0] d, input logic b);
    tx_data  = d;
    baudrate = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; baudrate = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if ({uart_txd, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state got=%b want=100", {uart_txd, tx_busy, tx_done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame(input logic [7:0] d, input logic b, input string name);
    int p;
    logic [7:0] rx;
    p  = period(b);
    rx = 8'h00;
    start_frame(d, b);
    for (int j = 0; j < NBITS * p; j++) begin
      vectors++;
      if ({uart_txd, tx_busy, tx_done} !== {exp_txd(d, j, p), 2'b10}) begin
        errors++;
        $display("FAIL %s cycle %0d got=%b want=%b", name, j, {uart_txd, tx_busy, tx_done},
                 {exp_txd(d, j, p), 2'b10});
      end
      if (j % p == p / 2 && j / p >= 1 && j / p <= 8) rx[j/p-1] = uart_txd;
      if (j == 3 * p) begin
        tx_data  = 8'($urandom);
        baudrate = 1'($urandom);
      end
      @(negedge clk);
    end
    vectors++;
    if ({uart_txd, tx_busy, tx_done} !== 3'b101) begin
      errors++;
      $display("FAIL %s done_cycle got=%b want=101", name, {uart_txd, tx_busy, tx_done});
    end
    @(negedge clk);
    vectors++;
    if ({uart_txd, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL %s after_done got=%b want=100", name, {uart_txd, tx_busy, tx_done});
    end
    vectors++;
    if (rx !== d) begin
      errors++;
      $display("FAIL %s loopback got=%h want=%h", name, rx, d);
    end
  endtask

  task automatic test_ignore_busy();
    int p;
    int dones;
    p = period(1'b0);
    dones = 0;
    start_frame(8'h0F, 1'b0);
    for (int j = 0; j < NBITS * p; j++) begin
      vectors++;
      if ({uart_txd, tx_busy, tx_done} !== {exp_txd(8'h0F, j, p), 2'b10}) begin
        errors++;
        $display("FAIL ignore_busy cycle %0d got=%b want=%b", j, {uart_txd, tx_busy, tx_done},
                 {exp_txd(8'h0F, j, p), 2'b10});
      end
      tx_start = (j == 5 * p + 3);
      if (j == 5 * p + 3) begin
        tx_data  = 8'hFF;
        baudrate = 1'b1;
      end
      @(negedge clk);
    end
    for (int j = 0; j < 2 * p; j++) begin
      if (tx_done) dones++;
      if (j > 0) begin
        vectors++;
        if ({uart_txd, tx_busy} !== 2'b10) begin
          errors++;
          $display("FAIL ignore_busy idle %0d got=%b want=10", j, {uart_txd, tx_busy});
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_busy done_count got=%0d want=1", dones);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    logic [7:0] data_q[2];
    logic [7:0] rx;
    p = period(1'b0);
    data_q[0] = 8'h00;
    data_q[1] = 8'h81;
    tx_data  = data_q[0];
    baudrate = 1'b0;
    tx_start = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      rx = 8'h00;
      for (int j = 0; j < NBITS * p; j++) begin
        vectors++;
        if ({uart_txd, tx_busy, tx_done} !== {exp_txd(data_q[f], j, p), 2'b10}) begin
          errors++;
          $display("FAIL back_to_back frame %0d cycle %0d got=%b want=%b", f, j,
                   {uart_txd, tx_busy, tx_done}, {exp_txd(data_q[f], j, p), 2'b10});
        end
        if (j % p == p / 2 && j / p >= 1 && j / p <= 8) rx[j/p-1] = uart_txd;
        if (f == 1) tx_start = 1'b0;
        @(negedge clk);
      end
      vectors++;
      if ({uart_txd, tx_busy, tx_done} !== 3'b101) begin
        errors++;
        $display("FAIL back_to_back done %0d got=%b want=101", f, {uart_txd, tx_busy, tx_done});
      end
      vectors++;
      if (rx !== data_q[f]) begin
        errors++;
        $display("FAIL back_to_back loopback %0d got=%h want=%h", f, rx, data_q[f]);
      end
      if (f == 0) tx_data = data_q[1];
      @(negedge clk);
    end
    vectors++;
    if ({uart_txd, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL back_to_back final_idle got=%b want=100", {uart_txd, tx_busy, tx_done});
    end
  endtask

  task automatic test_reset_midframe();
    int p;
    p = period(1'b0);
    start_frame(8'h3C, 1'b0);
    repeat (5 * p + p / 2) @(negedge clk);
    vectors++;
    if (tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid busy_before got=%b want=1", tx_busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({uart_txd, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid immediate got=%b want=100", {uart_txd, tx_busy, tx_done});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 3 * p; j++) begin
      @(negedge clk);
      vectors++;
      if ({uart_txd, tx_busy, tx_done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_mid quiet %0d got=%b want=100", j, {uart_txd, tx_busy, tx_done});
      end
    end
    test_frame(8'hC3, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_frame(8'($urandom), 1'($urandom), "random");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_frame(8'h55, 1'b0, "pattern_55");
    test_frame(8'hA3, 1'b1, "pattern_a3");
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
    test_frame(8'h07, 1'b0, "parity_07");
    test_frame(8'h03, 1'b0, "parity_03");
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
